dlx_mdr_ctrl: RTL and testbench

//   Parametrised memory data register with sub-word load/store alignment and a
//   req/ack memory handshake. Sits between datapath (store data, S2 bus) and the

---
 rtl/dlx_mdr_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_dlx_mdr_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mdr_ctrl.sv
// -----------------------------------------------------------------------------
// dlx_mdr_ctrl
//   Memory data register (MDR) controller for the DLX datapath. It aligns
//   sub-word stores onto the correct byte lanes and extracts, then zero- or
//   sign-extends, sub-word loads from the shared data bus. A req/ack handshake
//   with the memory provides wait states, a timeout and misalignment errors.
//
//   State sequence:  IDLE -> ACCESS -> DONE -> IDLE
//                    IDLE -> ERR -> IDLE   (misaligned request)
//                    ACCESS -> ERR         (no ack within TIMEOUT cycles)
//
// Parameters
//   DATA_W   data / MDR width, 32 or 64
//   TIMEOUT  ACCESS cycles without ack before the access is abandoned (>= 1)
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_reset        asynchronous active-high reset
//   i_mem_start    start an access (sampled in IDLE only)
//   i_mem_rw       1 = store, 0 = load
//   i_size         00 byte, 01 half, 10 word, 11 dword (DATA_W = 64 only)
//   i_sign_ext     loads: 1 sign-extend, 0 zero-extend
//   i_addr_lo      low address bits selecting the starting byte lane
//   i_store_data   store operand, right-justified
//   i_mdr_oe_s2    drive MDR onto the S2 bus
//   o_s2_bus       MDR when i_mdr_oe_s2, otherwise high-Z
//   io_data_bus    shared memory data bus; driven with MDR only during a
//                  store in ACCESS
//   o_mem_req      memory request, high throughout ACCESS
//   o_mem_we       write strobe (latched rw) while o_mem_req
//   o_mem_be       byte enables, valid while o_mem_req
//   i_mem_ack      memory completes the access this cycle
//   o_busy         controller not in IDLE
//   o_done         one-cycle pulse, access completed
//   o_err          one-cycle pulse, misaligned or timed out
// -----------------------------------------------------------------------------
module dlx_mdr_ctrl #(
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_mem_start,
   input  logic                            i_mem_rw,
   input  logic [1:0]                      i_size,
   input  logic                            i_sign_ext,
   input  logic [$clog2(DATA_W/8)-1:0]     i_addr_lo,
   input  logic [DATA_W-1:0]               i_store_data,
   input  logic                            i_mdr_oe_s2,
   output wire logic [DATA_W-1:0]          o_s2_bus,
   inout  wire logic [DATA_W-1:0]          io_data_bus,
   output logic                            o_mem_req,
   output logic                            o_mem_we,
   output logic [DATA_W/8-1:0]             o_mem_be,
   input  logic                            i_mem_ack,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_err
);

   localparam int BYTES = DATA_W / 8;
   localparam int AW    = $clog2(BYTES);
   localparam int TW    = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   // Bit mask covering the low (1 << size) bytes of a word.
   function automatic logic [DATA_W-1:0] width_mask(input logic [1:0] size);
      case (size)
         2'b00:   width_mask = DATA_W'(8'hFF);
         2'b01:   width_mask = DATA_W'(16'hFFFF);
         2'b10:   width_mask = DATA_W'(32'hFFFF_FFFF);
         default: width_mask = {DATA_W{1'b1}};
      endcase
   endfunction

   // Byte-enable pattern for an access of (1 << size) bytes at lane 0.
   function automatic logic [BYTES-1:0] lane_mask(input logic [1:0] size);
      case (size)
         2'b00:   lane_mask = BYTES'(8'h01);
         2'b01:   lane_mask = BYTES'(8'h03);
         2'b10:   lane_mask = BYTES'(8'h0F);
         default: lane_mask = {BYTES{1'b1}};
      endcase
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [AW-1:0] align_mask(input logic [1:0] size);
      case (size)
         2'b00:   align_mask = AW'(3'd0);
         2'b01:   align_mask = AW'(3'd1);
         2'b10:   align_mask = AW'(3'd3);
         default: align_mask = AW'(3'd7);
      endcase
   endfunction

   // Most significant bit of the loaded field, used for sign extension.
   function automatic logic sign_bit(input logic [DATA_W-1:0] data,
                                     input logic [1:0]        size);
      case (size)
         2'b00:   sign_bit = data[7];
         2'b01:   sign_bit = data[15];
         2'b10:   sign_bit = data[31];
         default: sign_bit = data[DATA_W-1];
      endcase
   endfunction

   // Registered state
   state_t              r_state;
   logic [DATA_W-1:0]   r_mdr;
   logic [TW-1:0]       r_timer;
   logic                r_rw;
   logic [1:0]          r_size;
   logic                r_sign_ext;
   logic [AW-1:0]       r_addr_lo;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [BYTES-1:0]    r_mem_be;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   // Next-state values
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   w_mdr_nxt;
   logic [TW-1:0]       w_timer_nxt;
   logic                w_rw_nxt;
   logic [1:0]          w_size_nxt;
   logic                w_sign_ext_nxt;
   logic [AW-1:0]       w_addr_lo_nxt;
   logic                w_mem_req_nxt;
   logic                w_mem_we_nxt;
   logic [BYTES-1:0]    w_mem_be_nxt;
   logic                w_busy_nxt;
   logic                w_done_nxt;
   logic                w_err_nxt;

   // Datapath helpers
   logic                w_misaligned;
   logic [DATA_W-1:0]   w_store_aligned;
   logic [BYTES-1:0]    w_be_aligned;
   logic [DATA_W-1:0]   w_shifted;
   logic [DATA_W-1:0]   w_load_mask;
   logic [DATA_W-1:0]   w_load_val;

   // Request checks and lane alignment for an access starting in IDLE.
   always_comb begin
      // A dword request can only be legal when the bus is 8 bytes wide.
      w_misaligned    = ((i_size == 2'b11) && (BYTES < 8)) ||
                        ((i_addr_lo & align_mask(i_size)) != {AW{1'b0}});
      w_store_aligned = (i_store_data & width_mask(i_size)) << {i_addr_lo, 3'b000};
      w_be_aligned    = lane_mask(i_size) << i_addr_lo;
   end

   // Load field extraction: shift the addressed lane down, then extend.
   always_comb begin
      w_shifted   = io_data_bus >> {r_addr_lo, 3'b000};
      w_load_mask = width_mask(r_size);
      if (r_sign_ext && sign_bit(w_shifted, r_size)) begin
         w_load_val = (w_shifted & w_load_mask) | ~w_load_mask;
      end else begin
         w_load_val = w_shifted & w_load_mask;
      end
   end

   // Next-state and next-output logic of the access FSM.
   always_comb begin
      w_state_nxt    = r_state;
      w_mdr_nxt      = r_mdr;
      w_timer_nxt    = r_timer;
      w_rw_nxt       = r_rw;
      w_size_nxt     = r_size;
      w_sign_ext_nxt = r_sign_ext;
      w_addr_lo_nxt  = r_addr_lo;
      w_mem_be_nxt   = {BYTES{1'b0}};

      case (r_state)
         ST_IDLE: begin
            if (i_mem_start) begin
               w_rw_nxt       = i_mem_rw;
               w_size_nxt     = i_size;
               w_sign_ext_nxt = i_sign_ext;
               w_addr_lo_nxt  = i_addr_lo;
               if (w_misaligned) begin
                  w_state_nxt = ST_ERR;
               end else begin
                  w_state_nxt  = ST_ACCESS;
                  w_timer_nxt  = {TW{1'b0}};
                  w_mem_be_nxt = w_be_aligned;
                  // Stores present the lane-aligned operand for the whole access.
                  if (i_mem_rw) begin
                     w_mdr_nxt = w_store_aligned;
                  end else begin
                     w_mdr_nxt = r_mdr;
                  end
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            // An ack arriving on the timeout edge still completes the access.
            if (i_mem_ack) begin
               w_state_nxt = ST_DONE;
               if (!r_rw) begin
                  w_mdr_nxt = w_load_val;
               end else begin
                  w_mdr_nxt = r_mdr;
               end
            end else if (r_timer == TW'(TIMEOUT - 1)) begin
               w_state_nxt = ST_ERR;
            end else begin
               w_state_nxt  = ST_ACCESS;
               w_timer_nxt  = r_timer + TW'(1);
               w_mem_be_nxt = r_mem_be;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         ST_ERR: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Outputs are registered from the next state so they change with it.
      w_mem_req_nxt = (w_state_nxt == ST_ACCESS);
      w_mem_we_nxt  = (w_state_nxt == ST_ACCESS) && w_rw_nxt;
      w_busy_nxt    = (w_state_nxt != ST_IDLE);
      w_done_nxt    = (w_state_nxt == ST_DONE);
      w_err_nxt     = (w_state_nxt == ST_ERR);
   end

   // State, MDR and output registers with asynchronous clear.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_mdr      <= {DATA_W{1'b0}};
         r_timer    <= {TW{1'b0}};
         r_rw       <= 1'b0;
         r_size     <= 2'b00;
         r_sign_ext <= 1'b0;
         r_addr_lo  <= {AW{1'b0}};
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_be   <= {BYTES{1'b0}};
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_mdr      <= w_mdr_nxt;
         r_timer    <= w_timer_nxt;
         r_rw       <= w_rw_nxt;
         r_size     <= w_size_nxt;
         r_sign_ext <= w_sign_ext_nxt;
         r_addr_lo  <= w_addr_lo_nxt;
         r_mem_req  <= w_mem_req_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_mem_be   <= w_mem_be_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_err      <= w_err_nxt;
      end
   end

   // The data bus is only driven while a store is in ACCESS (r_mem_we), so
   // an asynchronous reset releases it at once.
   assign io_data_bus = r_mem_we    ? r_mdr : {DATA_W{1'bz}};
   assign o_s2_bus    = i_mdr_oe_s2 ? r_mdr : {DATA_W{1'bz}};

   assign o_mem_req = r_mem_req;
   assign o_mem_we  = r_mem_we;
   assign o_mem_be  = r_mem_be;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_err     = r_err;

endmodule

// File: tb/tb_dlx_mdr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dlx_mdr_ctrl
//   Directed bench for dlx_mdr_ctrl (DATA_W = 32, TIMEOUT = 4). Expected values
//   are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_dlx_mdr_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_start;
   logic        mem_rw;
   logic [1:0]  size;
   logic        sign_ext;
   logic [1:0]  addr_lo;
   logic [31:0] store_data;
   logic        mdr_oe_s2;
   wire  [31:0] s2_bus;
   wire  [31:0] data_bus;
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic        busy;
   logic        done;
   logic        err;

   logic        tb_en;
   logic [31:0] tb_val;

   int checks = 0;
   int errors = 0;

   assign data_bus = tb_en ? tb_val : 32'hzzzz_zzzz;

   always #5 clk = ~clk;

   dlx_mdr_ctrl #(.DATA_W(32), .TIMEOUT(4)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_mem_start  (mem_start),
      .i_mem_rw     (mem_rw),
      .i_size       (size),
      .i_sign_ext   (sign_ext),
      .i_addr_lo    (addr_lo),
      .i_store_data (store_data),
      .i_mdr_oe_s2  (mdr_oe_s2),
      .o_s2_bus     (s2_bus),
      .io_data_bus  (data_bus),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_mem_be     (mem_be),
      .i_mem_ack    (mem_ack),
      .o_busy       (busy),
      .o_done       (done),
      .o_err        (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // An undriven net reads as Z in four-state simulators and 0 in two-state ones.
   function automatic logic [31:0] released(input logic [31:0] v);
      return {31'h0, ((v === 32'hzzzz_zzzz) || (v === 32'h0000_0000))};
   endfunction

   // Full access: start, optional wait cycles, ack, done pulse, MDR readback.
   task automatic run_op(input string tag, input logic rw, input logic [1:0] sz,
                         input logic sx, input logic [1:0] a, input logic [31:0] sd,
                         input logic [31:0] bus, input int waits,
                         input logic [3:0] exp_be, input logic [31:0] exp_mdr);
      @(negedge clk);
      mem_start = 1'b1; mem_rw = rw; size = sz; sign_ext = sx; addr_lo = a;
      store_data = sd; tb_val = bus; tb_en = !rw;
      @(negedge clk);
      mem_start = 1'b0;
      check({tag, ".req"},  32'(mem_req), 32'h1);
      check({tag, ".we"},   32'(mem_we),  32'(rw));
      check({tag, ".be"},   32'(mem_be),  32'(exp_be));
      if (rw) check({tag, ".bus"}, data_bus, exp_mdr);
      repeat (waits) @(negedge clk);
      check({tag, ".req_hold"}, 32'(mem_req), 32'h1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check({tag, ".done"}, 32'(done), 32'h1);
      check({tag, ".err"},  32'(err),  32'h0);
      check({tag, ".req_off"}, 32'(mem_req), 32'h0);
      check({tag, ".busy_done"}, 32'(busy), 32'h1);
      if (rw) check({tag, ".bus_rel"}, released(data_bus), 32'h1);
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(done), 32'h0);
      check({tag, ".idle"}, 32'(busy), 32'h0);
      mdr_oe_s2 = 1'b1;
      #1;
      check({tag, ".mdr"}, s2_bus, exp_mdr);
      mdr_oe_s2 = 1'b0;
      tb_en = 1'b0;
   endtask

   // Misaligned or oversized request: err pulse, no request, MDR unchanged.
   task automatic run_misaligned(input string tag, input logic [1:0] sz,
                                 input logic [1:0] a, input logic [31:0] exp_mdr);
      @(negedge clk);
      mem_start = 1'b1; mem_rw = 1'b0; size = sz; sign_ext = 1'b0; addr_lo = a;
      tb_en = 1'b0;
      @(negedge clk);
      mem_start = 1'b0;
      check({tag, ".err"},  32'(err),     32'h1);
      check({tag, ".req"},  32'(mem_req), 32'h0);
      check({tag, ".be"},   32'(mem_be),  32'h0);
      check({tag, ".busy"}, 32'(busy),    32'h1);
      check({tag, ".done"}, 32'(done),    32'h0);
      @(negedge clk);
      check({tag, ".err_pulse"}, 32'(err), 32'h0);
      check({tag, ".idle"}, 32'(busy), 32'h0);
      check({tag, ".s2_rel"}, released(s2_bus), 32'h1);
      mdr_oe_s2 = 1'b1;
      #1;
      check({tag, ".mdr"}, s2_bus, exp_mdr);
      mdr_oe_s2 = 1'b0;
   endtask

   initial begin
      reset = 1'b1; mem_start = 1'b0; mem_rw = 1'b0; size = 2'b00; sign_ext = 1'b0;
      addr_lo = 2'd0; store_data = 32'h0; mdr_oe_s2 = 1'b1; mem_ack = 1'b0;
      tb_en = 1'b0; tb_val = 32'h0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst.req",  32'(mem_req), 32'h0);
      check("rst.we",   32'(mem_we),  32'h0);
      check("rst.be",   32'(mem_be),  32'h0);
      check("rst.busy", 32'(busy),    32'h0);
      check("rst.done", 32'(done),    32'h0);
      check("rst.err",  32'(err),     32'h0);
      check("rst.s2",   s2_bus,       32'h0);
      check("rst.bus",  released(data_bus), 32'h1);
      reset = 1'b0;
      mdr_oe_s2 = 1'b0;

      // Loads
      run_op("lw",   1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'hDEAD_BEEF, 2, 4'b1111, 32'hDEAD_BEEF);
      run_op("lb",   1'b0, 2'b00, 1'b1, 2'd3, 32'h0, 32'h8011_2233, 0, 4'b1000, 32'hFFFF_FF80);
      run_op("lbu",  1'b0, 2'b00, 1'b0, 2'd3, 32'h0, 32'h8011_2233, 1, 4'b1000, 32'h0000_0080);
      run_op("lh",   1'b0, 2'b01, 1'b1, 2'd2, 32'h0, 32'h8011_2233, 1, 4'b1100, 32'hFFFF_8011);
      run_op("lhu0", 1'b0, 2'b01, 1'b0, 2'd0, 32'h0, 32'h8011_A233, 0, 4'b0011, 32'h0000_A233);

      // Stores
      run_op("sb",   1'b1, 2'b00, 1'b0, 2'd1, 32'h1234_56AB, 32'h0, 2, 4'b0010, 32'h0000_AB00);
      run_op("sh",   1'b1, 2'b01, 1'b0, 2'd2, 32'h0000_CAFE, 32'h0, 0, 4'b1100, 32'hCAFE_0000);

      // Ack while idle is ignored
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      check("idle_ack.busy", 32'(busy),    32'h0);
      check("idle_ack.done", 32'(done),    32'h0);
      check("idle_ack.req",  32'(mem_req), 32'h0);

      // Misaligned / oversized
      run_misaligned("mis_lh1", 2'b01, 2'd1, 32'hCAFE_0000);
      run_misaligned("mis_lw2", 2'b10, 2'd2, 32'hCAFE_0000);
      run_misaligned("mis_d",   2'b11, 2'd0, 32'hCAFE_0000);

      // Timeout: four ACCESS cycles without ack
      @(negedge clk);
      mem_start = 1'b1; mem_rw = 1'b0; size = 2'b10; sign_ext = 1'b0; addr_lo = 2'd0;
      tb_en = 1'b1; tb_val = 32'h1357_9BDF;
      @(negedge clk);
      mem_start = 1'b0;
      check("to.req1", 32'(mem_req), 32'h1);
      repeat (3) @(negedge clk);
      check("to.req4", 32'(mem_req), 32'h1);
      check("to.err4", 32'(err),     32'h0);
      @(negedge clk);
      check("to.err",  32'(err),     32'h1);
      check("to.req",  32'(mem_req), 32'h0);
      check("to.done", 32'(done),    32'h0);
      check("to.busy", 32'(busy),    32'h1);
      @(negedge clk);
      check("to.idle", 32'(busy),    32'h0);
      mdr_oe_s2 = 1'b1;
      #1;
      check("to.mdr", s2_bus, 32'hCAFE_0000);
      mdr_oe_s2 = 1'b0;
      tb_en = 1'b0;

      // Ack on the timeout edge completes normally
      run_op("ack_edge", 1'b0, 2'b10, 1'b0, 2'd0, 32'h0, 32'h0BAD_F00D, 3, 4'b1111, 32'h0BAD_F00D);

      // mem_start held high through ACCESS and DONE with a different request
      @(negedge clk);
      mem_start = 1'b1; mem_rw = 1'b0; size = 2'b10; sign_ext = 1'b0; addr_lo = 2'd0;
      tb_en = 1'b1; tb_val = 32'h1122_3344;
      @(negedge clk);
      mem_rw = 1'b1; size = 2'b00; addr_lo = 2'd1; store_data = 32'h0000_00EE;
      check("busy_start.we", 32'(mem_we), 32'h0);
      check("busy_start.be", 32'(mem_be), 32'hF);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      mem_start = 1'b0;
      check("busy_start.done", 32'(done), 32'h1);
      @(negedge clk);
      check("busy_start.idle", 32'(busy), 32'h0);
      check("busy_start.req",  32'(mem_req), 32'h0);
      mdr_oe_s2 = 1'b1;
      #1;
      check("busy_start.mdr", s2_bus, 32'h1122_3344);
      mdr_oe_s2 = 1'b0;
      tb_en = 1'b0;

      // Asynchronous reset in the middle of a store
      @(negedge clk);
      mem_start = 1'b1; mem_rw = 1'b1; size = 2'b10; addr_lo = 2'd0;
      store_data = 32'h5A5A_A5A5;
      @(negedge clk);
      mem_start = 1'b0;
      check("mid_rst.req0", 32'(mem_req), 32'h1);
      check("mid_rst.bus0", data_bus, 32'h5A5A_A5A5);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst.req",  32'(mem_req), 32'h0);
      check("mid_rst.we",   32'(mem_we),  32'h0);
      check("mid_rst.busy", 32'(busy),    32'h0);
      check("mid_rst.bus",  released(data_bus), 32'h1);
      @(negedge clk);
      reset = 1'b0;
      mdr_oe_s2 = 1'b1;
      #1;
      check("mid_rst.mdr", s2_bus, 32'h0);
      mdr_oe_s2 = 1'b0;
      @(negedge clk);
      check("mid_rst.idle", 32'(busy), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
